// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial pattern detector with Moore match pulse, match counting and target stop.
// Optional no-match timeout is built only when SEQ_CTRL_TIMEOUT_EN is defined.
module seq_detect_ctrl #(
  parameter int MAX_LEN   = 8,
  parameter int CNT_W     = 8,
  parameter int TO_CYCLES = 64,
  localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               din,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nx;
  logic [MAX_LEN-1:0] r_pattern, r_shreg, w_shift, w_mask;
  logic [LEN_W-1:0]   r_len, r_fill, w_fill_nx, w_len_eff;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target, r_cnt, w_cnt_inc;
  logic               r_dout, r_done, r_busy;
  logic               w_load_cfg, w_start_run, w_run_step;
  logic               w_match_raw, w_match, w_hit_target, w_to_hit;

  // Length clamp, shift window and match compare against the low L pattern bits.
  always_comb begin
    w_len_eff = cfg_len;
    if (cfg_len == {LEN_W{1'b0}}) begin
      w_len_eff = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      w_len_eff = LEN_W'(MAX_LEN);
    end else begin
      w_len_eff = cfg_len;
    end
    w_mask = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    w_shift      = {r_shreg[MAX_LEN-2:0], din};
    w_fill_nx    = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    w_match_raw  = (w_fill_nx >= r_len) && ((w_shift & w_mask) == (r_pattern & w_mask));
    w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    w_hit_target = (r_target != {CNT_W{1'b0}}) && (w_cnt_inc == r_target);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and datapath strobes; config beats start, abort beats a match.
  always_comb begin
    w_state_nx  = r_state;
    w_load_cfg  = 1'b0;
    w_start_run = 1'b0;
    w_run_step  = 1'b0;
    w_match     = 1'b0;
    cfg_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          w_load_cfg = 1'b1;
          w_state_nx = S_ARMED;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_ARMED: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          w_load_cfg = 1'b1;
        end else if (start) begin
          w_start_run = 1'b1;
          w_state_nx  = S_RUN;
        end else begin
          w_state_nx = S_ARMED;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nx = S_ARMED;
        end else begin
          w_run_step = 1'b1;
          w_match    = w_match_raw;
          if (w_match_raw && w_hit_target) begin
            w_state_nx = S_DONE;
          end else if (w_to_hit) begin
            w_state_nx = S_ARMED;
          end else begin
            w_state_nx = S_RUN;
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_ARMED;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Config, shift register, fill, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pattern <= {MAX_LEN{1'b0}};
      r_len     <= {LEN_W{1'b0}};
      r_overlap <= 1'b0;
      r_target  <= {CNT_W{1'b0}};
      r_shreg   <= {MAX_LEN{1'b0}};
      r_fill    <= {LEN_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_dout    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_dout <= w_match;
      r_done <= (w_state_nx == S_DONE);
      r_busy <= (w_state_nx == S_RUN);
      if (w_load_cfg) begin
        r_pattern <= cfg_pattern;
        r_len     <= w_len_eff;
        r_overlap <= cfg_overlap;
        r_target  <= cfg_target;
      end
      if (w_start_run) begin
        r_shreg <= {MAX_LEN{1'b0}};
        r_fill  <= {LEN_W{1'b0}};
        r_cnt   <= {CNT_W{1'b0}};
      end else if (w_run_step) begin
        r_shreg <= w_shift;
        if (w_match) begin
          r_cnt  <= w_cnt_inc;
          r_fill <= r_overlap ? w_fill_nx : {LEN_W{1'b0}};
        end else begin
          r_fill <= w_fill_nx;
        end
      end
    end
  end

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  assign w_to_hit = (r_state == S_RUN) && !abort && !w_match_raw &&
                    (r_to_cnt == TO_W'(TO_CYCLES - 1));
  assign timeout  = r_timeout;

  // Cycles since start or the last match; a same-edge match suppresses the timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to_cnt  <= {TO_W{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (w_start_run || w_match) begin
        r_to_cnt <= {TO_W{1'b0}};
      end else if (w_run_step) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign dout      = r_dout;
  assign done      = r_done;
  assign busy      = r_busy;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: expected match pulses are queued as stimulus is issued,
// and a negedge monitor pops and compares each dout/done pulse.
module tb_seq_detect_ctrl;
  localparam int MAX_LEN   = 8;
  localparam int CNT_W     = 8;
  localparam int LEN_W     = 4;
  localparam int TO_CYCLES = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               din = 1'b0;
  logic               dout;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               timeout;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .start(start), .abort(abort), .din(din),
    .dout(dout), .match_cnt(match_cnt), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   bit_idx;
    int   cnt;
    logic done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_bit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every dout/done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (dout === 1'b1 || done === 1'b1)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: dout=%0b done=%0b after bit %0d, expected no pulse",
                 dout, done, last_bit);
      end else begin
        e = sb.pop_front();
        chk("pulse_bit", last_bit, e.bit_idx);
        chk("pulse_cnt", match_cnt, e.cnt);
        chk("pulse_done", done, e.done);
        chk("pulse_dout", dout, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    last_bit = 0;
  endtask

  task automatic send(input int idx, input logic b);
    din = b;
    tick();
    last_bit = idx;
  endtask

  task automatic push(input int b, input int c, input logic d);
    exp_t e;
    e.bit_idx = b;
    e.cnt     = c;
    e.done    = d;
    sb.push_back(e);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic [7:0] tgt);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_run();
    din   = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic drain(input string name, input logic d);
    din = d;
    tick();
    tick();
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b1;
    tick();

    // Overlapping 1010, unlimited target
    cfg(8'h0A, 4'd4, 1'b1, 8'd0);
    go();
    chk("t1_busy", busy, 1);
    chk("t1_cfg_ready", cfg_ready, 0);
    push(4, 1, 1'b0); push(6, 2, 1'b0); push(8, 3, 1'b0); push(10, 4, 1'b0);
    for (int i = 1; i <= 11; i++) send(i, logic'(i % 2));
    drain("t1_missing", 1'b1);
    chk("t1_cnt", match_cnt, 4);
    stop_run();
    chk("t1_busy_after_abort", busy, 0);

    // Non-overlapping
    cfg(8'h0A, 4'd4, 1'b0, 8'd0);
    go();
    push(4, 1, 1'b0); push(8, 2, 1'b0);
    for (int i = 1; i <= 11; i++) send(i, logic'(i % 2));
    drain("t2_missing", 1'b1);
    chk("t2_cnt", match_cnt, 2);
    stop_run();

    // Target of 3 ends the run with done on the third pulse
    cfg(8'h0A, 4'd4, 1'b1, 8'd3);
    go();
    push(4, 1, 1'b0); push(6, 2, 1'b0); push(8, 3, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      send(i, logic'(i % 2));
      if (i == 9) begin
        chk("t3_cfg_ready", cfg_ready, 1);
        chk("t3_busy", busy, 0);
      end
    end
    drain("t3_missing", 1'b1);
    chk("t3_cnt_hold", match_cnt, 3);
    chk("t3_done_low", done, 0);

    // Abort on the edge of the second match
    cfg(8'h0A, 4'd4, 1'b1, 8'd0);
    go();
    push(4, 1, 1'b0);
    for (int i = 1; i <= 5; i++) send(i, logic'(i % 2));
    abort = 1'b1;
    send(6, 1'b0);
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_cnt", match_cnt, 1);
    cfg_pattern = 8'h06; cfg_len = 4'd3; cfg_overlap = 1'b1; cfg_target = 8'd0;
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("t4_cfg_wins_busy", busy, 0);
    chk("t4_cfg_wins_ready", cfg_ready, 1);
    go();
    push(3, 1, 1'b0);
    send(1, 1'b1); send(2, 1'b1); send(3, 1'b0);
    drain("t4_newcfg_missing", 1'b0);
    chk("t4_newcfg_cnt", match_cnt, 1);
    stop_run();

    // Reset during a run
    cfg(8'h0A, 4'd4, 1'b1, 8'd0);
    go();
    push(4, 1, 1'b0);
    for (int i = 1; i <= 5; i++) send(i, logic'(i % 2));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t5_dout", dout, 0);
    chk("t5_cnt", match_cnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_cfg_ready", cfg_ready, 1);
    go();
    chk("t5_start_ignored", busy, 0);
    for (int i = 1; i <= 4; i++) send(i, logic'(i % 2));
    drain("t5_no_pulses", 1'b0);

    // cfg_len = 0 behaves as length 1
    cfg(8'h01, 4'd0, 1'b1, 8'd0);
    go();
    push(1, 1, 1'b0); push(3, 2, 1'b0);
    send(1, 1'b1); send(2, 1'b0); send(3, 1'b1);
    drain("t6_len0_missing", 1'b0);
    chk("t6_len0_cnt", match_cnt, 2);
    stop_run();

    // cfg_len above MAX_LEN clamps to 8 bits
    cfg(8'hA5, 4'd15, 1'b1, 8'd0);
    go();
    push(8, 1, 1'b0);
    begin
      logic [7:0] pat;
      pat = 8'hA5;
      for (int i = 1; i <= 8; i++) send(i, pat[8 - i]);
    end
    drain("t6_clamp_missing", 1'b0);
    chk("t6_clamp_cnt", match_cnt, 1);
    stop_run();

    // Counter saturation
    cfg(8'h01, 4'd1, 1'b1, 8'd0);
    go();
    for (int i = 1; i <= 260; i++) begin
      push(i, (i > 255) ? 255 : i, 1'b0);
      send(i, 1'b1);
    end
    drain("t6_sat_missing", 1'b0);
    chk("t6_sat_cnt", match_cnt, 255);
    stop_run();

    // No-match timeout
    cfg(8'h0A, 4'd4, 1'b1, 8'd0);
    go();
`ifdef SEQ_CTRL_TIMEOUT_EN
    for (int i = 1; i <= TO_CYCLES; i++) begin
      send(i, 1'b0);
      chk("t7_timeout", timeout, (i == TO_CYCLES) ? 1 : 0);
    end
    chk("t7_done", done, 0);
    chk("t7_busy", busy, 0);
    chk("t7_cfg_ready", cfg_ready, 1);
    tick();
    chk("t7_timeout_pulse", timeout, 0);
`else
    for (int i = 1; i <= 12; i++) begin
      send(i, 1'b0);
      chk("t7_timeout", timeout, 0);
    end
    chk("t7_busy", busy, 1);
    stop_run();
`endif
    drain("t7_no_pulses", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
